// File: rtl/ecc_mem_pkg.sv
// Shared memory-bus types for the core-side arbiter.
//   BusID              requester tag {core_id, component_type}
//   memory_address_t   64-bit memory address
//   bus_packet_type_t  kind of memory response
//   arb_state_t        request FSM states of memory_bus_arbiter
//   createBusID()      builds a BusID from core id and component type
package ecc_mem_pkg;

  localparam int BUS_ID_W   = 8;
  localparam int MEM_ADDR_W = 64;

  typedef logic [BUS_ID_W-1:0]   BusID;
  typedef logic [MEM_ADDR_W-1:0] memory_address_t;

  typedef enum logic {
    bus_read_response,
    bus_write_ack
  } bus_packet_type_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_ISSUE
  } arb_state_t;

  localparam logic [3:0] COMPONENT_TYPE_FETCH = 4'd0;
  localparam logic [3:0] COMPONENT_TYPE_LOAD  = 4'd1;
  localparam logic [3:0] COMPONENT_TYPE_STORE = 4'd2;
  localparam logic [3:0] COMPONENT_TYPE_DMA   = 4'd3;

  function automatic BusID createBusID(input logic [3:0] core_id,
                                       input logic [3:0] component_type);
    return {core_id, component_type};
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the eligible vector so rr_ptr
// lands at bit 0, take the lowest set bit, rotate the grant back.
//   eligible   in   NUM_REQ  candidates this cycle
//   rr_ptr     in   PTR_W    highest-priority index
//   grant      out  NUM_REQ  one-hot grant, or 0 when nothing is eligible
//   grant_idx  out  PTR_W    index of the granted bit
//   grant_any  out  1        any candidate eligible
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_any
);

  localparam logic [PTR_W:0] NUM_REQ_W = NUM_REQ[PTR_W:0];

  logic [2*NUM_REQ-1:0] shifted;
  logic [2*NUM_REQ-1:0] unrotated;
  logic [NUM_REQ-1:0]   rot_onehot;
  logic [PTR_W-1:0]     rot_idx;
  logic [PTR_W:0]       idx_sum;

  always_comb begin
    shifted    = {eligible, eligible} >> rr_ptr;
    rot_onehot = '0;
    rot_idx    = '0;
    // Scan downwards so the lowest set bit is the one left standing.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (shifted[k]) begin
        rot_onehot    = '0;
        rot_onehot[k] = 1'b1;
        rot_idx       = k[PTR_W-1:0];
      end
    end
    unrotated = {rot_onehot, rot_onehot} << rr_ptr;
    grant     = unrotated[2*NUM_REQ-1:NUM_REQ];
    idx_sum   = {1'b0, rot_idx} + {1'b0, rr_ptr};
    if (idx_sum >= NUM_REQ_W) begin
      idx_sum = idx_sum - NUM_REQ_W;
    end
    grant_idx = idx_sum[PTR_W-1:0];
    grant_any = |eligible;
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Shares one memory bus among NUM_REQ requesters. Requests are granted
// round-robin and tagged with the requester's BusID; responses are routed
// back by BusID. Each requester has at most one transaction in flight.
//   clk, reset                    clock, async active-high reset
//   req_valid/ready/write         per-requester request handshake
//   req_addr/wdata/id             flattened per-requester request fields
//   mem_req_valid/ready/write/addr/wdata/id   request to memory
//   mem_rsp_valid/ready/id/data   response from memory
//   rsp_valid/ready               per-requester response handshake
//   rsp_data                      shared response payload
//   err_unexp_rsp                 sticky: response nobody was waiting for
//
// state     | meaning
// ARB_IDLE  | looking for an eligible requester to grant
// ARB_ISSUE | latched request on the bus, waiting for mem_req_ready
module memory_bus_arbiter
  import ecc_mem_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int ID_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  output logic [ID_W-1:0]           mem_req_id,
  input  logic                      mem_rsp_valid,
  output logic                      mem_rsp_ready,
  input  logic [ID_W-1:0]           mem_rsp_id,
  input  logic [DATA_W-1:0]         mem_rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      err_unexp_rsp
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  arb_state_t state, state_nxt;

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_any;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] pending, pending_nxt;
  logic [NUM_REQ-1:0] rsp_valid_nxt;
  logic [NUM_REQ-1:0] match, match_first;
  logic [ID_W-1:0]    id_tab [NUM_REQ];
  logic               grant_en;
  logic               issue_done;
  logic               rsp_accept;

  assign eligible = req_valid & ~pending & ~rsp_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .grant     (pick_onehot),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // req_ready is combinational, so it is gated by reset to read 0 while
  // reset is held even if requesters are already asserting req_valid.
  always_comb begin
    state_nxt     = state;
    grant_en      = 1'b0;
    issue_done    = 1'b0;
    req_ready     = '0;
    mem_req_valid = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any && !reset) begin
          grant_en  = 1'b1;
          req_ready = pick_onehot;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          issue_done = 1'b1;
          state_nxt  = ARB_IDLE;
        end
      end
    endcase
  end

  // Lowest index wins when two pending requesters share a BusID.
  always_comb begin
    match       = '0;
    match_first = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      match[i] = pending[i] && (id_tab[i] == mem_rsp_id);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (match[i]) begin
        match_first    = '0;
        match_first[i] = 1'b1;
      end
    end
  end

  // rsp_data is a single register, so any held response blocks the memory
  // side. A held requester is never pending, so this never stalls a
  // response that could have been delivered without overwriting data.
  assign mem_rsp_ready = ~|rsp_valid;
  assign rsp_accept    = mem_rsp_valid && mem_rsp_ready;

  // Grant and response touch different requesters: a granted one was not
  // pending, so it cannot match the response in the same cycle.
  always_comb begin
    pending_nxt   = pending;
    rsp_valid_nxt = rsp_valid & ~rsp_ready;
    if (rsp_accept) begin
      pending_nxt   = pending_nxt & ~match_first;
      rsp_valid_nxt = rsp_valid_nxt | match_first;
    end
    if (grant_en) begin
      pending_nxt = pending_nxt | pick_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      gnt_idx       <= '0;
      pending       <= '0;
      rsp_valid     <= '0;
      rsp_data      <= '0;
      err_unexp_rsp <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_id    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        id_tab[i] <= '0;
      end
    end else begin
      pending   <= pending_nxt;
      rsp_valid <= rsp_valid_nxt;
      if (grant_en) begin
        gnt_idx          <= pick_idx;
        mem_req_write    <= req_write[pick_idx];
        mem_req_addr     <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        mem_req_wdata    <= req_wdata[pick_idx*DATA_W +: DATA_W];
        mem_req_id       <= req_id[pick_idx*ID_W +: ID_W];
        id_tab[pick_idx] <= req_id[pick_idx*ID_W +: ID_W];
      end
      if (issue_done) begin
        rr_ptr <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
      end
      if (rsp_accept && (|match)) begin
        rsp_data <= mem_rsp_data;
      end
      if (rsp_accept && !(|match)) begin
        err_unexp_rsp <= 1'b1;
      end
    end
  end

endmodule
